// File: rtl/ring_counter.sv
// One-hot ring counter: a single set bit rotates toward the MSB every clock and wraps to bit 0.
// Optional feature macro RING_COUNTER_SELF_CORRECT_EN reloads RESET_VAL when the state is not one-hot.
module ring_counter #(
   parameter int unsigned           WIDTH     = 8,
   parameter logic [WIDTH-1:0]      RESET_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] ring_r;
   logic [WIDTH-1:0] next_s;

`ifdef RING_COUNTER_SELF_CORRECT_EN
   // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
   function automatic logic is_one_hot(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] low_cleared;
      low_cleared = v & (v - {{(WIDTH-1){1'b0}}, 1'b1});
      return (v != {WIDTH{1'b0}}) && (low_cleared == {WIDTH{1'b0}});
   endfunction
`endif

   // Next ring state: rotate left by one, or reload when the state is corrupted.
   always_comb begin
      next_s = {ring_r[WIDTH-2:0], ring_r[WIDTH-1]};
`ifdef RING_COUNTER_SELF_CORRECT_EN
      if (!is_one_hot(ring_r)) begin
         next_s = RESET_VAL;
      end else begin
         next_s = {ring_r[WIDTH-2:0], ring_r[WIDTH-1]};
      end
`endif
   end

   // Ring register; reset loads the seed immediately and wins over a coincident edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ring_r <= RESET_VAL;
      end else begin
         ring_r <= next_s;
      end
   end

   assign out = ring_r;

endmodule

// File: tb/tb_ring_counter.sv
// Directed bench for ring_counter with a queue scoreboard; covers reset, rotation,
// wrap, async reset mid-sequence, reset on a clock edge, and corrupted-state handling.
module tb_ring_counter;

   logic       clk;
   logic       reset;
   logic [7:0] out;

   int         total;
   int         bad;
   logic [7:0] exp_r;
   logic [7:0] sb_q[$];

   ring_counter #(.WIDTH(8), .RESET_VAL(8'h01)) dut (
      .clk   (clk),
      .reset (reset),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference next state, written from the behavioural description.
   function automatic logic [7:0] model_next(input logic [7:0] v);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(v[i]);
`ifdef RING_COUNTER_SELF_CORRECT_EN
      if (ones != 1) return 8'h01;
`endif
      return {v[6:0], v[7]};
   endfunction

   task automatic compare(input string tag);
      logic [7:0] want;
      want = sb_q.pop_front();
      total++;
      assert (out === want)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, out, want);
      end
   endtask

   task automatic expect_now(input string tag, input logic [7:0] v);
      sb_q.push_back(v);
      compare(tag);
   endtask

   task automatic step(input string tag);
      exp_r = model_next(exp_r);
      sb_q.push_back(exp_r);
      @(negedge clk);
      compare(tag);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      exp_r = 8'h01;

      #1;
      expect_now("async_reset", 8'h01);
      @(negedge clk);
      expect_now("reset_held", 8'h01);
      reset = 1'b0;
      #1;
      expect_now("release", 8'h01);

      // Three full laps from reset.
      for (int i = 0; i < 24; i++) begin
         step($sformatf("lap_edge%0d", i + 1));
      end

      // Advance to 8'h20, then assert reset between edges.
      for (int i = 0; i < 5; i++) step("to_20");
      #2;
      reset = 1'b1;
      #1;
      expect_now("async_mid", 8'h01);
      @(negedge clk);
      expect_now("mid_held", 8'h01);
      reset = 1'b0;
      exp_r = 8'h01;
      step("resume_02");
      step("resume_04");

      // Advance to 8'h80, then raise reset exactly on a clock edge.
      for (int i = 0; i < 5; i++) step("to_80");
      @(posedge clk);
      reset = 1'b1;
      #1;
      expect_now("edge_reset", 8'h01);
      @(negedge clk);
      expect_now("edge_held", 8'h01);
      reset = 1'b0;
      exp_r = 8'h01;
      step("after_edge_02");

      // Corrupted states injected directly into the ring register.
      force dut.ring_r = 8'h00;
      #1;
      release dut.ring_r;
      exp_r = 8'h00;
      expect_now("forced_00", 8'h00);
      step("recover_00");
      #1;
      force dut.ring_r = 8'h11;
      #1;
      release dut.ring_r;
      exp_r = 8'h11;
      expect_now("forced_11", 8'h11);
`ifdef RING_COUNTER_SELF_CORRECT_EN
      exp_r = 8'h01;
      sb_q.push_back(8'h01);
`else
      exp_r = 8'h22;
      sb_q.push_back(8'h22);
`endif
      @(negedge clk);
      compare("edge_after_11");
      step("second_after_11");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
